cpu_exec_scheduler: RTL

CPU_EXEC_SCHEDULER -- requirements
Module: cpu_exec_scheduler

---
 rtl/cpu_exec_scheduler_pkg.sv | 22 ++
 rtl/cpu_exec_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_scheduler_pkg.sv
// Shared CPU definitions used by the execute-stage scheduler.
// Holds the ISA ALU opcode constants, the scheduler state type and a small
// opcode classification helper.
package cpu_exec_scheduler_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ISA_ADD_OP = 4'h0;
  localparam logic [ALU_OP_W-1:0] ISA_SUB_OP = 4'h1;
  localparam logic [ALU_OP_W-1:0] ISA_MUL_OP = 4'h2;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } sched_state_e;

  // Only MUL is multi-cycle; every other encoding completes in one cycle.
  function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
    return (op == ISA_MUL_OP);
  endfunction

endpackage

// File: rtl/cpu_exec_scheduler.sv
// Execute-stage scheduler: sequences single-cycle ALU ops and a fixed-latency
// multiplier onto one in-order writeback slot.
// Ports: clock/reset; issue_* from decode with issue_ready back; flush kills
// in-flight work; alu_start to the datapath; result_* writeback slot;
// pend_valid/pend_dest expose the in-flight MUL destination for forwarding.
// MUL_LATENCY must lie in 2..8.
module cpu_exec_scheduler
  import cpu_exec_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = 5,
  parameter int REG_W       = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ALU_OP_W-1:0] issue_alu_op,
  input  logic                issue_reg_write,
  input  logic                issue_commit,
  input  logic [REG_W-1:0]    issue_reg_dest,
  input  logic                flush,
  output logic                issue_ready,
  output logic                alu_start,
  output logic                result_valid,
  output logic                result_reg_write,
  output logic                result_commit,
  output logic [REG_W-1:0]    result_reg_dest,
  output logic                pend_valid,
  output logic [REG_W-1:0]    pend_dest
);

  localparam int              CNT_W    = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Controls of the multiply currently in flight.
  logic             mul_wr_q, mul_wr_d;
  logic             mul_cm_q, mul_cm_d;
  logic [REG_W-1:0] mul_dest_q, mul_dest_d;

  // Writeback slot registers.
  logic             res_vld_q, res_vld_d;
  logic             res_wr_q, res_wr_d;
  logic             res_cm_q, res_cm_d;
  logic [REG_W-1:0] res_dest_q, res_dest_d;

  // A single-cycle op accepted while a result already owns the next slot
  // (the MUL completion, or an earlier deferred op) waits here one cycle,
  // keeping writeback strictly in order with no lost slot.
  logic             dfr_vld_q, dfr_vld_d;
  logic             dfr_wr_q, dfr_wr_d;
  logic             dfr_cm_q, dfr_cm_d;
  logic [REG_W-1:0] dfr_dest_q, dfr_dest_d;

  logic last_busy;
  logic accept;

  assign last_busy   = (state_q == ST_MUL_BUSY) && (cnt_q == CNT_ONE);
  assign issue_ready = (state_q == ST_IDLE) || (cnt_q == CNT_ONE);
  assign accept      = issue_valid & issue_ready & ~flush & ~reset;
  assign alu_start   = accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_wr_d   = mul_wr_q;
    mul_cm_d   = mul_cm_q;
    mul_dest_d = mul_dest_q;
    res_vld_d  = 1'b0;
    res_wr_d   = 1'b0;
    res_cm_d   = 1'b0;
    res_dest_d = res_dest_q;
    dfr_vld_d  = 1'b0;
    dfr_wr_d   = dfr_wr_q;
    dfr_cm_d   = dfr_cm_q;
    dfr_dest_d = dfr_dest_q;

    if (flush) begin
      // Everything in flight dies; the slot after a flush is always a bubble.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      if (state_q == ST_MUL_BUSY) begin
        cnt_d = cnt_q - CNT_ONE;
        if (last_busy) begin
          state_d    = ST_IDLE;
          res_vld_d  = 1'b1;
          res_wr_d   = mul_wr_q;
          res_cm_d   = mul_cm_q;
          res_dest_d = mul_dest_q;
        end
      end else if (dfr_vld_q) begin
        res_vld_d  = 1'b1;
        res_wr_d   = dfr_wr_q;
        res_cm_d   = dfr_cm_q;
        res_dest_d = dfr_dest_q;
      end

      if (accept) begin
        if (is_mul_op(issue_alu_op)) begin
          state_d    = ST_MUL_BUSY;
          cnt_d      = CNT_LOAD;
          mul_wr_d   = issue_reg_write;
          mul_cm_d   = issue_commit;
          mul_dest_d = issue_reg_dest;
        end else if (last_busy || dfr_vld_q) begin
          dfr_vld_d  = 1'b1;
          dfr_wr_d   = issue_reg_write;
          dfr_cm_d   = issue_commit;
          dfr_dest_d = issue_reg_dest;
        end else begin
          res_vld_d  = 1'b1;
          res_wr_d   = issue_reg_write;
          res_cm_d   = issue_commit;
          res_dest_d = issue_reg_dest;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mul_wr_q   <= 1'b0;
      mul_cm_q   <= 1'b0;
      mul_dest_q <= '0;
      res_vld_q  <= 1'b0;
      res_wr_q   <= 1'b0;
      res_cm_q   <= 1'b0;
      res_dest_q <= '0;
      dfr_vld_q  <= 1'b0;
      dfr_wr_q   <= 1'b0;
      dfr_cm_q   <= 1'b0;
      dfr_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_wr_q   <= mul_wr_d;
      mul_cm_q   <= mul_cm_d;
      mul_dest_q <= mul_dest_d;
      res_vld_q  <= res_vld_d;
      res_wr_q   <= res_wr_d;
      res_cm_q   <= res_cm_d;
      res_dest_q <= res_dest_d;
      dfr_vld_q  <= dfr_vld_d;
      dfr_wr_q   <= dfr_wr_d;
      dfr_cm_q   <= dfr_cm_d;
      dfr_dest_q <= dfr_dest_d;
    end
  end

  assign result_valid     = res_vld_q;
  assign result_reg_write = res_wr_q;
  assign result_commit    = res_cm_q;
  assign result_reg_dest  = res_dest_q;
  assign pend_valid       = (state_q == ST_MUL_BUSY);
  assign pend_dest        = mul_dest_q;

endmodule
